// File: rtl/jump_target_unit.sv
// jump_target_unit: two-stage valid/ready next-PC target generator (J, BRANCH, JR)
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake
//   mode                       00 J, 01 BRANCH, 10 JR, 11 reserved
//   pc_plus4, index, imm       PC+4, jump index field, branch offset
//   reg_target                 register value for JR
//   out_valid/out_ready        result handshake
//   target, out_mode           computed target and its mode
//   mode_err                   result came from reserved mode 11
//   misalign                   JR target not word aligned (only with JTU_ALIGN_CHECK_EN)
// Optional feature macro: JTU_ALIGN_CHECK_EN
module jump_target_unit #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 26,
  parameter int IMM_W   = 16,
  parameter int SHIFT   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  pc_plus4,
  input  logic [INDEX_W-1:0] index,
  input  logic [IMM_W-1:0]   imm,
  input  logic [ADDR_W-1:0]  reg_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  target,
  output logic [1:0]         out_mode,
  output logic               mode_err,
  output logic               misalign
);
  logic               r_live;
  logic               r_s1_valid;
  logic [1:0]         r_mode;
  logic [ADDR_W-1:0]  r_pc;
  logic [INDEX_W-1:0] r_index;
  logic [IMM_W-1:0]   r_imm;
  logic [ADDR_W-1:0]  r_reg;
  logic               r_s2_valid;
  logic [ADDR_W-1:0]  r_target;
  logic [1:0]         r_out_mode;
  logic               r_mode_err;
  logic               w_s2_load;
  logic               w_s1_load;
  logic               w_s1_move;
  logic [ADDR_W-1:0]  w_j;
  logic [ADDR_W-1:0]  w_sext;
  logic [ADDR_W-1:0]  w_br;
  logic [ADDR_W-1:0]  w_tgt;
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_s1_move = r_s1_valid && w_s2_load;
  // r_live holds in_ready low until the first edge after reset release
  assign in_ready  = r_live && w_s1_load;
  assign out_valid = r_s2_valid;
  assign target    = r_target;
  assign out_mode  = r_out_mode;
  assign mode_err  = r_mode_err;
  generate
    if (ADDR_W > INDEX_W + SHIFT) begin : g_j_upper
      assign w_j = {r_pc[ADDR_W-1:INDEX_W+SHIFT], r_index, {SHIFT{1'b0}}};
    end else begin : g_j_flat
      assign w_j = {r_index, {SHIFT{1'b0}}};
    end
  endgenerate
  assign w_sext = {{(ADDR_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};
  assign w_br   = r_pc + (w_sext << SHIFT);
  always_comb begin
    w_tgt = r_mode == 2'b00 ? w_j :
            r_mode == 2'b01 ? w_br :
            r_mode == 2'b10 ? r_reg : r_pc;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live     <= 1'b0;
      r_s1_valid <= 1'b0;
      r_mode     <= '0;
      r_pc       <= '0;
      r_index    <= '0;
      r_imm      <= '0;
      r_reg      <= '0;
      r_s2_valid <= 1'b0;
      r_target   <= '0;
      r_out_mode <= '0;
      r_mode_err <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_s1_load) r_s1_valid <= in_valid && r_live;
      if (in_ready && in_valid) begin
        r_mode  <= mode;
        r_pc    <= pc_plus4;
        r_index <= index;
        r_imm   <= imm;
        r_reg   <= reg_target;
      end
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_s1_move) begin
        r_target   <= w_tgt;
        r_out_mode <= r_mode;
        r_mode_err <= r_mode == 2'b11;
      end
    end
  end
`ifdef JTU_ALIGN_CHECK_EN
  logic r_misalign;
  assign misalign = r_misalign;
  // J/BRANCH targets are aligned by construction, so only JR is checked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_misalign <= 1'b0;
    else if (w_s1_move) r_misalign <= r_mode == 2'b10 && r_reg[SHIFT-1:0] != '0;
  end
`else
  assign misalign = 1'b0;
`endif
endmodule

// File: tb/tb_jump_target_unit.sv
// tb_jump_target_unit: directed scoreboard bench for jump_target_unit
module tb_jump_target_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] pc_plus4;
  logic [25:0] index;
  logic [15:0] imm;
  logic [31:0] reg_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] target;
  logic [1:0]  out_mode;
  logic        mode_err;
  logic        misalign;
  typedef struct packed {
    logic [31:0] t;
    logic [1:0]  m;
    logic        e;
    logic        mis;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  exp_t held;
  exp_t got;
  logic prev_stall = 1'b0;
  int checks = 0;
  int errors = 0;
  int acc;
  always #5 clk = ~clk;
  jump_target_unit dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .pc_plus4(pc_plus4), .index(index), .imm(imm),
    .reg_target(reg_target), .out_valid(out_valid), .out_ready(out_ready),
    .target(target), .out_mode(out_mode), .mode_err(mode_err), .misalign(misalign)
  );
  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    got = '{target, out_mode, mode_err, misalign};
    if (reset_n) begin
      if (prev_stall) check("stall_hold", {3'b0, out_valid, got}, {4'b0001, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", {35'b0, out_valid}, 36'b0);
        else check("result", {4'b0, got}, {4'b0, sb.pop_front()});
      end
      prev_stall = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) sb.push_back(cur);
    end else prev_stall = 1'b0;
  end
  task automatic drive(input logic [1:0] m, input logic [31:0] pc, input logic [25:0] ix,
                       input logic [15:0] im, input logic [31:0] rg, input logic [31:0] et,
                       input logic emis);
    logic ok;
    mode = m; pc_plus4 = pc; index = ix; imm = im; reg_target = rg;
`ifdef JTU_ALIGN_CHECK_EN
    cur = '{et, m, m == 2'b11, emis};
`else
    cur = '{et, m, m == 2'b11, 1'b0};
`endif
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", {35'b0, in_ready}, 36'b1);
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", {35'b0, sb.size() == 0}, 36'b1);
  endtask
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 2'b00;
    pc_plus4 = '0; index = '0; imm = '0; reg_target = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {35'b0, out_valid}, 36'b0);
    check("rst_outputs", {1'b0, target, out_mode, mode_err, misalign}, 36'b0);
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", {35'b0, in_ready}, 36'b1);
    out_ready = 1'b1;
    drive(2'b00, 32'hE000_0004, 26'h0087AAA, 16'h0, 32'h0, 32'hE021_EAA8, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("latency_valid", {35'b0, out_valid}, 36'b1);
    check("j_target", {2'b0, target, out_mode}, {2'b0, 32'hE021_EAA8, 2'b00});
    drain();
    drive(2'b01, 32'h0000_1000, 26'h0, 16'hFFFF, 32'h0, 32'h0000_0FFC, 1'b0);
    drive(2'b01, 32'h0000_1000, 26'h0, 16'h0010, 32'h0, 32'h0000_1040, 1'b0);
    drive(2'b01, 32'h0000_0004, 26'h0, 16'hFFFE, 32'h0, 32'hFFFF_FFFC, 1'b0);
    drive(2'b10, 32'h0000_0000, 26'h0, 16'h0, 32'h0040_0002, 32'h0040_0002, 1'b1);
    drive(2'b11, 32'h1234_5678, 26'h0, 16'h0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    drive(2'b10, 32'h0000_0000, 26'h0, 16'h0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    drive(2'b00, 32'h7FFF_FFFF, 26'h3FFFFFF, 16'h0, 32'h0, 32'h7FFF_FFFC, 1'b0);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      mode = 2'b00; pc_plus4 = 32'h3000_0000; index = 26'(acc + 1);
      cur = '{32'h3000_0000 | 32'((acc + 1) << 2), 2'b00, 1'b0, 1'b0};
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 36'(acc), 36'd2);
    check("bp_in_ready", {35'b0, in_ready}, 36'b0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    drive(2'b01, 32'h0000_2000, 26'h0, 16'h0001, 32'h0, 32'h0000_2004, 1'b0);
    drive(2'b01, 32'h0000_2000, 26'h0, 16'h0002, 32'h0, 32'h0000_2008, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_valid", {35'b0, out_valid}, 36'b0);
    sb.delete();
    #13 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midreset", {35'b0, in_ready}, 36'b1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_stale", {35'b0, out_valid}, 36'b0);
    drive(2'b10, 32'h0, 26'h0, 16'h0, 32'h0000_1234, 32'h0000_1234, 1'b0);
    in_valid = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
